// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: shared widths, FSM encodings and address field helpers
package icache_ctrl_pkg;
   localparam int ADDR_W    = 16;
   localparam int TAG_W     = 8;
   localparam int IDX_W     = 6;
   localparam int OFF_W     = 2;
   localparam int NUM_LINES = 64;
   localparam int WORD_W    = 16;
   localparam int LINE_W    = 64;
   localparam int MADDR_W   = 14;
   localparam int CNT_W     = 16;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
      return a[OFF_W-1:0];
   endfunction

   // counters stick at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch-side and line-memory-side signals of the instruction cache
interface icache_ctrl_if;
   import icache_ctrl_pkg::*;
   logic [ADDR_W-1:0]  if_addr;
   logic               if_re;
   logic               flush;
   logic [WORD_W-1:0]  instr;
   logic               if_stall;
   logic [MADDR_W-1:0] mem_addr;
   logic               mem_re;
   logic               mem_rdy;
   logic [LINE_W-1:0]  mem_rd_data;
   logic [CNT_W-1:0]   hit_cnt;
   logic [CNT_W-1:0]   miss_cnt;

   modport slave (
      input  if_addr, if_re, flush, mem_rdy, mem_rd_data,
      output instr, if_stall, mem_addr, mem_re, hit_cnt, miss_cnt
   );

   modport master (
      output if_addr, if_re, flush, mem_rdy, mem_rd_data,
      input  instr, if_stall, mem_addr, mem_re, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/icache_ctrl_array.sv
// icache_array: tag and data storage with one combinational read port and one line write port
module icache_array
   import icache_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line
);
   logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
   logic [LINE_W-1:0] data_mem [NUM_LINES];

   // whole-line fill; validity is tracked by the controller so no reset here
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   assign rd_tag  = tag_mem[rd_idx];
   assign rd_line = data_mem[rd_idx];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller with miss fill, flash flush and hit/miss counters
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input logic         clk,
   input logic         rst,
   icache_ctrl_if.slave bus
);
   logic [1:0]           state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [MADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                 mem_re_q, mem_re_d;
   logic                 flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_W-1:0]    rd_line;
   logic [IDX_W-1:0]     wr_idx;
   logic                 idle, hit, fill;

   assign idle   = state_q == S_IDLE;
   assign hit    = idle & valid_q[idx_of(bus.if_addr)] & (rd_tag == tag_of(bus.if_addr));
   assign fill   = (state_q == S_WAIT) & bus.mem_rdy;
   assign wr_idx = mem_addr_q[IDX_W-1:0];

   icache_array u_array (
      .clk     (clk),
      .rd_idx  (idx_of(bus.if_addr)),
      .rd_tag  (rd_tag),
      .rd_line (rd_line),
      .we      (fill & ~rst),
      .wr_idx  (wr_idx),
      .wr_tag  (mem_addr_q[MADDR_W-1 -: TAG_W]),
      .wr_line (bus.mem_rd_data)
   );

   assign bus.instr    = hit ? rd_line[{off_of(bus.if_addr), 4'b0000} +: WORD_W] : '0;
   assign bus.if_stall = bus.if_re & ~hit | (state_q == S_FLUSH);
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_re   = mem_re_q;
   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;

   // next-state: lookup/miss launch in IDLE, fill completion in WAIT, flash clear in FLUSH
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      mem_addr_d   = mem_addr_q;
      mem_re_d     = mem_re_q;
      flush_pend_d = flush_pend_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (state_q == S_IDLE) begin
         if (bus.if_re && hit) hit_cnt_d = sat_inc(hit_cnt_q);
         if (bus.flush) begin
            state_d = S_FLUSH;
         end else if (bus.if_re && !hit) begin
            state_d    = S_WAIT;
            mem_addr_d = bus.if_addr[ADDR_W-1:OFF_W];
            mem_re_d   = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
         end
      end else if (state_q == S_WAIT) begin
         flush_pend_d = flush_pend_q | bus.flush;
         if (bus.mem_rdy) begin
            valid_d[wr_idx] = 1'b1;
            mem_re_d        = 1'b0;
            flush_pend_d    = 1'b0;
            state_d         = (flush_pend_q | bus.flush) ? S_FLUSH : S_IDLE;
         end
      end else begin
         valid_d = '0;
         state_d = S_IDLE;
      end
   end

   // state registers; tag/data arrays deliberately left out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         mem_addr_q   <= '0;
         mem_re_q     <= 1'b0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_re_q     <= mem_re_d;
         flush_pend_q <= flush_pend_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed and table-driven checks of icache_ctrl against a line-memory model
module tb_icache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   st;
   logic [13:0] sa;
   logic [15:0] ins;

   icache_ctrl_if bus();
   icache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        re;
      logic        exp_stall;
      logic [15:0] exp_instr;
      logic [15:0] exp_hits;
   } vec_t;
   vec_t tbl[5];

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   function automatic logic [63:0] line_of(input logic [13:0] m);
      logic [15:0] b;
      b = {m, 2'b00};
      return {word_of(b + 16'd3), word_of(b + 16'd2), word_of(b + 16'd1), word_of(b)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // fetch addr until it stops stalling; answer the line request lat cycles after mem_re rises
   task automatic run_fetch(input logic [15:0] a, input int lat, output int stalls,
                            output logic [13:0] seen, output logic [15:0] got);
      int since;
      since = 0;
      stalls = 0;
      seen = '0;
      got = '0;
      bus.if_addr = a;
      bus.if_re = 1'b1;
      for (int c = 0; c < 50; c++) begin
         bus.mem_rdy = bus.mem_re && since == lat;
         bus.mem_rd_data = line_of(bus.mem_addr);
         #1;
         if (!bus.if_stall) begin
            got = bus.instr;
            tick();
            return;
         end
         stalls++;
         if (bus.mem_re) begin
            if (since == 0) seen = bus.mem_addr;
            since++;
         end
         tick();
         bus.mem_rdy = 1'b0;
      end
      total++;
      bad++;
      $display("FAIL fetch_timeout addr=%h", a);
   endtask

   initial begin
      tbl[0] = '{16'h0105, 1'b1, 1'b0, word_of(16'h0105), 16'd2};
      tbl[1] = '{16'h0106, 1'b1, 1'b0, word_of(16'h0106), 16'd3};
      tbl[2] = '{16'h0107, 1'b1, 1'b0, word_of(16'h0107), 16'd4};
      tbl[3] = '{16'h0300, 1'b0, 1'b0, 16'h0000,          16'd4};
      tbl[4] = '{16'h0104, 1'b1, 1'b0, word_of(16'h0104), 16'd5};
      bus.if_addr = '0;
      bus.if_re = 1'b0;
      bus.flush = 1'b0;
      bus.mem_rdy = 1'b0;
      bus.mem_rd_data = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_hit_cnt", bus.hit_cnt, 0);
      chk("rst_miss_cnt", bus.miss_cnt, 0);
      chk("rst_stall", bus.if_stall, 0);

      run_fetch(16'h0104, 3, st, sa, ins);
      chk("t1_stalls", st, 5);
      chk("t1_mem_addr", sa, 14'h0041);
      chk("t1_instr", ins, word_of(16'h0104));
      chk("t1_miss_cnt", bus.miss_cnt, 1);
      chk("t1_hit_cnt", bus.hit_cnt, 1);

      foreach (tbl[i]) begin
         bus.if_addr = tbl[i].addr;
         bus.if_re = tbl[i].re;
         #1;
         chk($sformatf("t2_stall_%0d", i), bus.if_stall, tbl[i].exp_stall);
         chk($sformatf("t2_instr_%0d", i), bus.instr, tbl[i].exp_instr);
         tick();
         chk($sformatf("t2_hits_%0d", i), bus.hit_cnt, tbl[i].exp_hits);
      end
      chk("t2_miss_cnt", bus.miss_cnt, 1);

      run_fetch(16'h0204, 3, st, sa, ins);
      chk("t3_conf_stalls", st, 5);
      chk("t3_conf_instr", ins, word_of(16'h0204));
      run_fetch(16'h0104, 3, st, sa, ins);
      chk("t3_refill_stalls", st, 5);
      chk("t3_refill_instr", ins, word_of(16'h0104));
      chk("t3_miss_cnt", bus.miss_cnt, 3);
      chk("t3_hit_cnt", bus.hit_cnt, 7);

      bus.if_addr = 16'h1234;
      bus.if_re = 1'b1;
      #1;
      chk("t4_miss_stall", bus.if_stall, 1);
      tick();
      chk("t4_mem_re", bus.mem_re, 1);
      chk("t4_mem_addr", bus.mem_addr, 14'h048D);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.mem_rdy = 1'b1;
      bus.mem_rd_data = line_of(bus.mem_addr);
      #1;
      chk("t4_fill_stall", bus.if_stall, 1);
      tick();
      bus.mem_rdy = 1'b0;
      #1;
      chk("t4_flush_mem_re", bus.mem_re, 0);
      chk("t4_flush_stall", bus.if_stall, 1);
      tick();
      run_fetch(16'h1234, 1, st, sa, ins);
      chk("t4_retry_stalls", st, 3);
      chk("t4_retry_instr", ins, word_of(16'h1234));
      chk("t4_miss_cnt", bus.miss_cnt, 5);
      run_fetch(16'h0104, 2, st, sa, ins);
      chk("t4_cleared_stalls", st, 4);
      chk("t4_hit_cnt", bus.hit_cnt, 9);

      bus.if_addr = 16'h0500;
      bus.flush = 1'b1;
      #1;
      chk("t4b_stall", bus.if_stall, 1);
      tick();
      bus.flush = 1'b0;
      bus.if_re = 1'b0;
      #1;
      chk("t4b_flush_stall", bus.if_stall, 1);
      tick();
      chk("t4b_idle_stall", bus.if_stall, 0);
      chk("t4b_miss_cnt", bus.miss_cnt, 6);
      chk("t4b_mem_re", bus.mem_re, 0);

      bus.if_addr = 16'h0208;
      bus.if_re = 1'b1;
      tick();
      chk("t5_mem_re", bus.mem_re, 1);
      chk("t5_mem_addr", bus.mem_addr, 14'h0082);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_mem_re", bus.mem_re, 0);
      chk("t5_rst_miss_cnt", bus.miss_cnt, 0);
      bus.if_re = 1'b0;
      bus.mem_rdy = 1'b1;
      bus.mem_rd_data = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      bus.mem_rdy = 1'b0;
      run_fetch(16'h0208, 0, st, sa, ins);
      chk("t5_late_stalls", st, 2);
      chk("t5_late_instr", ins, word_of(16'h0208));
      run_fetch(16'h0104, 0, st, sa, ins);
      chk("t5_valid_clr_stalls", st, 2);
      chk("t5_miss_cnt", bus.miss_cnt, 2);
      chk("t5_hit_cnt", bus.hit_cnt, 2);

      bus.if_addr = 16'h0104;
      bus.if_re = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      chk("t6_sat_hit_cnt", bus.hit_cnt, 16'hFFFF);
      chk("t6_sat_stall", bus.if_stall, 0);
      bus.if_re = 1'b0;
      bus.if_addr = 16'h0700;
      tick();
      tick();
      chk("t6_idle_stall", bus.if_stall, 0);
      chk("t6_idle_hit_cnt", bus.hit_cnt, 16'hFFFF);
      chk("t6_idle_miss_cnt", bus.miss_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
